// File: rtl/paridade_4bit.sv
// Registered 4-bit parity generator/checker with selectable even/odd sense
// and a saturating mismatch counter for the optional check path.
module paridade_4bit #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a3,
  input  logic                 a2,
  input  logic                 a1,
  input  logic                 a0,
  input  logic                 odd_sel,
  input  logic                 in_valid,
  input  logic                 chk_en,
  input  logic                 p_in,
  output logic                 p,
  output logic                 out_valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 w_x;
  logic                 w_p_next;
  logic                 w_mismatch;
  logic                 w_cnt_full;
  logic                 r_p;
  logic                 r_out_valid;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_comb begin
    w_x        = a3 ^ a2 ^ a1 ^ a0;
    w_p_next   = odd_sel ? ~w_x : w_x;
    w_mismatch = chk_en & (p_in != w_p_next);
    w_cnt_full = (r_err_cnt == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p         <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else if (in_valid) begin
      r_p         <= w_p_next;
      r_out_valid <= 1'b1;
      r_err       <= w_mismatch;
      // err still fires once the counter has saturated; only the count stops
      if (w_mismatch && !w_cnt_full)
        r_err_cnt <= r_err_cnt + 1'b1;
    end else begin
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end
  end

  assign p         = r_p;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_paridade_4bit.sv
// Self-checking bench for paridade_4bit: directed plan plus randomized traffic,
// checked against a popcount-based reference model (8-bit and 2-bit counters).
module tb_paridade_4bit;

  logic       clk = 1'b0;
  logic       rst_n, a3, a2, a1, a0, odd_sel, in_valid, chk_en, p_in;
  logic       p8, ov8, err8;
  logic [7:0] cnt8;
  logic       p2, ov2, err2;
  logic [1:0] cnt2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model state
  bit          m_p, m_ov, m_err;
  int unsigned m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  paridade_4bit #(.ERR_CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a3(a3), .a2(a2), .a1(a1), .a0(a0),
    .odd_sel(odd_sel), .in_valid(in_valid), .chk_en(chk_en), .p_in(p_in),
    .p(p8), .out_valid(ov8), .err(err8), .err_cnt(cnt8)
  );

  paridade_4bit #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a3(a3), .a2(a2), .a1(a1), .a0(a0),
    .odd_sel(odd_sel), .in_valid(in_valid), .chk_en(chk_en), .p_in(p_in),
    .p(p2), .out_valid(ov2), .err(err2), .err_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".p"},         {31'd0, p8},   {31'd0, m_p});
    chk({tag, ".out_valid"}, {31'd0, ov8},  {31'd0, m_ov});
    chk({tag, ".err"},       {31'd0, err8}, {31'd0, m_err});
    chk({tag, ".err_cnt8"},  {24'd0, cnt8}, m_cnt8);
    chk({tag, ".p_w2"},      {31'd0, p2},   {31'd0, m_p});
    chk({tag, ".ov_w2"},     {31'd0, ov2},  {31'd0, m_ov});
    chk({tag, ".err_w2"},    {31'd0, err2}, {31'd0, m_err});
    chk({tag, ".err_cnt2"},  {30'd0, cnt2}, m_cnt2);
  endtask

  // Drive one cycle, advance the model on the edge, then sample 1 ns later.
  task automatic step(input bit rn, input bit v, input bit odd, input bit ce,
                      input bit pi, input bit [3:0] nib, input string tag);
    bit pn;
    rst_n = rn; in_valid = v; odd_sel = odd; chk_en = ce; p_in = pi;
    {a3, a2, a1, a0} = nib;
    @(posedge clk);
    pn = (($countones(nib) % 2) == 1) ^ odd;
    if (!rn) begin
      m_p = 0; m_ov = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (v) begin
      m_p   = pn;
      m_ov  = 1;
      m_err = ce && (pi != pn);
      if (m_err && m_cnt8 < 255) m_cnt8++;
      if (m_err && m_cnt2 < 3)   m_cnt2++;
    end else begin
      m_ov = 0; m_err = 0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] even_seq;
    logic [15:0] odd_seq;
    logic [3:0]  prev_p_hold;
    even_seq = 16'b0110_1001_1001_0110;
    odd_seq  = 16'b1001_0110_0110_1001;
    rst_n = 0; in_valid = 0; odd_sel = 0; chk_en = 0; p_in = 0;
    {a3, a2, a1, a0} = 4'b0000;

    // reset
    step(0, 0, 0, 0, 0, 4'h0, "reset0");
    step(0, 1, 1, 1, 1, 4'h7, "reset1");

    // exhaustive even / odd sweeps against the listed sequences
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0, 0, i[3:0], "even_sweep");
      chk("even_seq", {31'd0, p8}, {31'd0, even_seq[15-i]});
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 1, 0, 0, i[3:0], "odd_sweep");
      chk("odd_seq", {31'd0, p8}, {31'd0, odd_seq[15-i]});
    end

    // check mode, even parity, nibble 1011 (parity 1)
    step(1, 1, 0, 1, 1, 4'b1011, "chk_match");
    chk("chk_match_err", {31'd0, err8}, 32'd0);
    step(1, 1, 0, 1, 0, 4'b1011, "chk_mismatch");
    chk("chk_mismatch_err", {31'd0, err8}, 32'd1);
    chk("chk_mismatch_cnt", {24'd0, cnt8}, 32'd1);
    step(1, 1, 0, 0, 0, 4'b1011, "chk_disabled");
    chk("chk_disabled_cnt", {24'd0, cnt8}, 32'd1);

    // saturation of the 2-bit counter: 1,2,3,3,3
    step(0, 0, 0, 0, 0, 4'h0, "sat_reset");
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 1, 1, 4'b0001, "sat");   // odd parity of 0001 is 0
      chk("sat_cnt2", {30'd0, cnt2}, (i < 3) ? i + 1 : 3);
      chk("sat_err2", {31'd0, err2}, 32'd1);
    end

    // valid gating while data toggles
    step(1, 1, 0, 1, 0, 4'b0111, "gate_pre");
    prev_p_hold = {3'd0, p8};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, i[0], 1, ~i[0], 4'hF ^ i[3:0], "gate");
      chk("gate_p_hold", {28'd0, 3'd0, p8}, {28'd0, prev_p_hold});
    end

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), $urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), "rand");
    end

    // synchronous reset with valid nibble 0001 and nonzero count
    step(1, 1, 0, 1, 0, 4'b0001, "pre_rst");
    chk("pre_rst_cnt_nonzero", {31'd0, (cnt8 != 0)}, 32'd1);
    step(0, 1, 0, 1, 0, 4'b0001, "mid_rst");
    chk("mid_rst_ov", {31'd0, ov8}, 32'd0);
    chk("mid_rst_cnt", {24'd0, cnt8}, 32'd0);
    step(1, 0, 0, 0, 0, 4'b0001, "post_rst");
    chk("post_rst_ov", {31'd0, ov8}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish by 200us");
    $fatal(1, "timeout");
  end

endmodule
